demux1_2_stream: RTL

//  Registered 1:2 demultiplexer for W-bit words with valid/ready handshake on every port.

---
 rtl/demux1_2_stream.sv | 97 +++++++++
 1 files changed

// File: rtl/demux1_2_stream.sv
// Registered 1:2 valid/ready demultiplexer: each word is steered by in_sel into a one-entry output slice.
// Optional per-output transfer counters are enabled with the DEMUX_CNT_EN macro.
module demux1_2_stream #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_a_data,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [W-1:0]     out_b_data,
    output logic             out_b_valid,
    input  logic             out_b_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slice_state_t;

    slice_state_t a_state, a_next;
    slice_state_t b_state, b_next;

    logic acc_a, acc_b;
    logic xfer_a, xfer_b;

    assign out_a_valid = (a_state == FULL);
    assign out_b_valid = (b_state == FULL);

    // Only the selected slice can block the input; the other one is ignored.
    assign in_ready = in_sel ? (~out_b_valid | out_b_ready)
                             : (~out_a_valid | out_a_ready);

    assign acc_a  = in_valid & in_ready & ~in_sel;
    assign acc_b  = in_valid & in_ready &  in_sel;
    assign xfer_a = out_a_valid & out_a_ready;
    assign xfer_b = out_b_valid & out_b_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_state <= EMPTY;
            b_state <= EMPTY;
        end else begin
            a_state <= a_next;
            b_state <= b_next;
        end
    end

    always_comb begin
        a_next = a_state;
        b_next = b_state;
        case (a_state)
            EMPTY:   if (acc_a) a_next = FULL;
            FULL:    if (xfer_a && !acc_a) a_next = EMPTY;
            default: a_next = EMPTY;
        endcase
        case (b_state)
            EMPTY:   if (acc_b) b_next = FULL;
            FULL:    if (xfer_b && !acc_b) b_next = EMPTY;
            default: b_next = EMPTY;
        endcase
    end

    // Data registers load only on accept, so they hold while stalled and after drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_a_data <= '0;
            out_b_data <= '0;
        end else begin
            if (acc_a) out_a_data <= in_data;
            if (acc_b) out_b_data <= in_data;
        end
    end

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (xfer_a) cnt_a <= cnt_a + 1'b1;
            if (xfer_b) cnt_b <= cnt_b + 1'b1;
        end
    end
`endif

endmodule
